branch_hazard_controller: RTL and testbench

- Sequences decode-stage branch resolution for the pipelined MIPS core.
- Detects when the decode-stage branch/jump comparator would read stale rs/rt values, and stalls IF/ID while inserting bubbles into ID/EX.
- Drives the forwarding selects for the comparator operand muxes, then issues the PC redirect and the IF/ID squash for taken branches.
- Keeps wrap-around performance counters for branches, taken branches and branch stall cycles.

---
 rtl/branch_hazard_controller_if.sv | 47 ++++
 rtl/branch_hazard_controller.sv | 152 +++++++++++++++
 tb/tb_branch_hazard_controller.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_hazard_controller_if.sv
// Decode-stage branch hazard bus: pipeline-side status in, stall/forward/redirect controls out.
interface branch_hazard_controller_if #(
    parameter int CNT_WIDTH = 32
);
    logic [2:0]           id_branch_variant;
    logic [4:0]           id_rs;
    logic [4:0]           id_rt;
    logic                 id_pc_src;
    logic [31:0]          id_jump_address;
    logic                 ex_reg_write;
    logic [4:0]           ex_write_reg;
    logic                 ex_mem_to_reg;
    logic                 mem_reg_write;
    logic [4:0]           mem_write_reg;
    logic                 mem_mem_to_reg;
    logic                 wb_reg_write;
    logic [4:0]           wb_write_reg;
    logic                 stall_if;
    logic                 stall_id;
    logic                 flush_ex;
    logic                 flush_id;
    logic [1:0]           fwd_rs_sel;
    logic [1:0]           fwd_rt_sel;
    logic                 pc_sel;
    logic [31:0]          pc_target;
    logic [CNT_WIDTH-1:0] branch_count;
    logic [CNT_WIDTH-1:0] taken_count;
    logic [CNT_WIDTH-1:0] stall_count;

    modport master (
        output id_branch_variant, id_rs, id_rt, id_pc_src, id_jump_address,
               ex_reg_write, ex_write_reg, ex_mem_to_reg,
               mem_reg_write, mem_write_reg, mem_mem_to_reg,
               wb_reg_write, wb_write_reg,
        input  stall_if, stall_id, flush_ex, flush_id, fwd_rs_sel, fwd_rt_sel,
               pc_sel, pc_target, branch_count, taken_count, stall_count
    );

    modport slave (
        input  id_branch_variant, id_rs, id_rt, id_pc_src, id_jump_address,
               ex_reg_write, ex_write_reg, ex_mem_to_reg,
               mem_reg_write, mem_write_reg, mem_mem_to_reg,
               wb_reg_write, wb_write_reg,
        output stall_if, stall_id, flush_ex, flush_id, fwd_rs_sel, fwd_rt_sel,
               pc_sel, pc_target, branch_count, taken_count, stall_count
    );
endinterface

// File: rtl/branch_hazard_controller.sv
// Decode-stage branch resolution: stalls on stale comparator operands, selects forwarding,
// redirects the PC on taken branches and keeps wrap-around branch performance counters.
module branch_hazard_controller #(
    parameter int CNT_WIDTH = 32
) (
    input logic                    clock,
    input logic                    reset_n,
    branch_hazard_controller_if.slave bus
);
    localparam logic [2:0] BV_NONE      = 3'd0;
    localparam logic [2:0] BV_BEQ       = 3'd1;
    localparam logic [2:0] BV_BNE       = 3'd2;
    localparam logic [2:0] BV_BLTZ      = 3'd3;
    localparam logic [2:0] BV_JUMP      = 3'd4;
    localparam logic [2:0] BV_JUMP_LINK = 3'd5;
    localparam logic [2:0] BV_JUMP_REG  = 3'd6;

    localparam logic [1:0] ST_NORMAL  = 2'd0;
    localparam logic [1:0] ST_STALL2  = 2'd1;
    localparam logic [1:0] ST_RESOLVE = 2'd2;

    logic [1:0]           state, state_nxt;
    logic                 uses_rs, uses_rt, active;
    logic [1:0]           need_rs, need_rt, need;
    logic                 stall, resolve, taken;
    logic [CNT_WIDTH-1:0] branch_cnt, taken_cnt, stall_cnt;

    function automatic logic [1:0] need_of(
        input logic [4:0] src,
        input logic       ex_rw, input logic [4:0] ex_wr, input logic ex_ld,
        input logic       mem_rw, input logic [4:0] mem_wr, input logic mem_ld
    );
        logic [1:0] n;
        n = '0;
        // The EX producer shadows an older MEM producer of the same register.
        if (src != '0) begin
            if (ex_rw && ex_wr == src)
                n = ex_ld ? 2'd2 : 2'd1;
            else if (mem_rw && mem_wr == src && mem_ld)
                n = 2'd1;
        end
        return n;
    endfunction

    function automatic logic [1:0] fwd_of(
        input logic       [4:0] src,
        input logic       mem_rw, input logic [4:0] mem_wr, input logic mem_ld,
        input logic       wb_rw, input logic [4:0] wb_wr
    );
        logic [1:0] f;
        f = '0;
        if (src != '0) begin
            if (mem_rw && mem_wr == src && !mem_ld)
                f = 2'd1;
            else if (wb_rw && wb_wr == src)
                f = 2'd2;
        end
        return f;
    endfunction

    always_comb begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        active  = 1'b1;
        case (bus.id_branch_variant)
            BV_BEQ, BV_BNE:          begin uses_rs = 1'b1; uses_rt = 1'b1; end
            BV_BLTZ, BV_JUMP_REG:    uses_rs = 1'b1;
            BV_JUMP, BV_JUMP_LINK:   active = 1'b1;
            default:                 active = 1'b0;
        endcase
    end

    always_comb begin
        need_rs = uses_rs ? need_of(bus.id_rs, bus.ex_reg_write, bus.ex_write_reg, bus.ex_mem_to_reg,
                                    bus.mem_reg_write, bus.mem_write_reg, bus.mem_mem_to_reg) : 2'd0;
        need_rt = uses_rt ? need_of(bus.id_rt, bus.ex_reg_write, bus.ex_write_reg, bus.ex_mem_to_reg,
                                    bus.mem_reg_write, bus.mem_write_reg, bus.mem_mem_to_reg) : 2'd0;
        need    = (need_rs > need_rt) ? need_rs : need_rt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        resolve   = 1'b0;
        if (!active) begin
            state_nxt = ST_NORMAL;
        end else begin
            case (state)
                ST_NORMAL: begin
                    if (need == 2'd0) begin
                        resolve = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = (need == 2'd2) ? ST_STALL2 : ST_RESOLVE;
                    end
                end
                ST_STALL2: begin
                    stall     = 1'b1;
                    state_nxt = ST_RESOLVE;
                end
                ST_RESOLVE: begin
                    resolve   = 1'b1;
                    state_nxt = ST_NORMAL;
                end
                default: state_nxt = ST_NORMAL;
            endcase
        end
        taken = resolve && bus.id_pc_src;
    end

    // Controls are masked while reset_n is low so the pipeline sees a quiet controller.
    always_comb begin
        bus.stall_if   = 1'b0;
        bus.stall_id   = 1'b0;
        bus.flush_ex   = 1'b0;
        bus.flush_id   = 1'b0;
        bus.pc_sel     = 1'b0;
        bus.pc_target  = '0;
        bus.fwd_rs_sel = '0;
        bus.fwd_rt_sel = '0;
        if (reset_n && active) begin
            bus.stall_if   = stall;
            bus.stall_id   = stall;
            bus.flush_ex   = stall;
            bus.flush_id   = taken;
            bus.pc_sel     = taken;
            bus.pc_target  = taken ? bus.id_jump_address : '0;
            bus.fwd_rs_sel = fwd_of(bus.id_rs, bus.mem_reg_write, bus.mem_write_reg, bus.mem_mem_to_reg,
                                    bus.wb_reg_write, bus.wb_write_reg);
            bus.fwd_rt_sel = fwd_of(bus.id_rt, bus.mem_reg_write, bus.mem_write_reg, bus.mem_mem_to_reg,
                                    bus.wb_reg_write, bus.wb_write_reg);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_NORMAL;
            branch_cnt <= '0;
            taken_cnt  <= '0;
            stall_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (resolve) branch_cnt <= branch_cnt + CNT_WIDTH'(1);
            if (taken)   taken_cnt  <= taken_cnt + CNT_WIDTH'(1);
            if (stall)   stall_cnt  <= stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign bus.branch_count = branch_cnt;
    assign bus.taken_count  = taken_cnt;
    assign bus.stall_count  = stall_cnt;
endmodule

// File: tb/tb_branch_hazard_controller.sv
// Bench for branch_hazard_controller: directed scenarios plus randomized traffic against a
// stall-countdown reference model; counters use a 4-bit width so wrap-around is reachable.
module tb_branch_hazard_controller;
    localparam int CW = 4;
    localparam logic [2:0] V_NONE = 3'd0, V_BEQ = 3'd1, V_BNE = 3'd2, V_BLTZ = 3'd3,
                           V_J = 3'd4, V_JAL = 3'd5, V_JR = 3'd6;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    branch_hazard_controller_if #(.CNT_WIDTH(CW)) bus();

    branch_hazard_controller #(.CNT_WIDTH(CW)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic set_id(input logic [2:0] v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic pc_src, input logic [31:0] addr);
        bus.id_branch_variant = v;
        bus.id_rs             = rs;
        bus.id_rt             = rt;
        bus.id_pc_src         = pc_src;
        bus.id_jump_address   = addr;
    endtask

    task automatic set_ex(input logic rw, input logic [4:0] wr, input logic ld);
        bus.ex_reg_write = rw; bus.ex_write_reg = wr; bus.ex_mem_to_reg = ld;
    endtask

    task automatic set_mem(input logic rw, input logic [4:0] wr, input logic ld);
        bus.mem_reg_write = rw; bus.mem_write_reg = wr; bus.mem_mem_to_reg = ld;
    endtask

    task automatic set_wb(input logic rw, input logic [4:0] wr);
        bus.wb_reg_write = rw; bus.wb_write_reg = wr;
    endtask

    task automatic idle_all();
        set_id(V_NONE, 5'd0, 5'd0, 1'b0, 32'h0);
        set_ex(1'b0, 5'd0, 1'b0);
        set_mem(1'b0, 5'd0, 1'b0);
        set_wb(1'b0, 5'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        idle_all();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clock);
        set_id(V_BEQ, 5'd1, 5'd2, 1'b1, 32'h1234);
        set_ex(1'b1, 5'd1, 1'b1);
        #2;
        tests_run++;
        if ({bus.stall_if, bus.flush_ex, bus.pc_sel, bus.flush_id} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_ctrl got %b want 0000", {bus.stall_if, bus.flush_ex, bus.pc_sel, bus.flush_id});
        end
        tests_run++;
        if ({bus.branch_count, bus.taken_count, bus.stall_count} !== '0) begin
            tests_failed++;
            $display("FAIL reset_counters got %h want 0", {bus.branch_count, bus.taken_count, bus.stall_count});
        end
        tests_run++;
        if (bus.pc_target !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_pc_target got %h want 0", bus.pc_target);
        end
        idle_all();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_taken_beq();
        do_reset();
        set_id(V_BEQ, 5'd1, 5'd2, 1'b1, 32'h0040_0040);
        #2;
        tests_run++;
        if ({bus.pc_sel, bus.flush_id, bus.stall_if} !== 3'b110 || bus.pc_target !== 32'h0040_0040) begin
            tests_failed++;
            $display("FAIL beq_taken got sel/flush/stall %b target %h want 110 00400040",
                     {bus.pc_sel, bus.flush_id, bus.stall_if}, bus.pc_target);
        end
        @(negedge clock);
        idle_all();
        #2;
        tests_run++;
        if (bus.branch_count !== 4'd1 || bus.taken_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL beq_counts got %0d/%0d want 1/1", bus.branch_count, bus.taken_count);
        end
    endtask

    task automatic test_ex_alu_hazard();
        do_reset();
        set_id(V_BNE, 5'd1, 5'd0, 1'b1, 32'h0000_0100);
        set_ex(1'b1, 5'd1, 1'b0);
        #2;
        tests_run++;
        if ({bus.stall_if, bus.stall_id, bus.flush_ex, bus.pc_sel} !== 4'b1110) begin
            tests_failed++;
            $display("FAIL alu_stall got %b want 1110", {bus.stall_if, bus.stall_id, bus.flush_ex, bus.pc_sel});
        end
        @(negedge clock);
        set_ex(1'b0, 5'd0, 1'b0);
        set_mem(1'b1, 5'd1, 1'b0);
        #2;
        tests_run++;
        if (bus.fwd_rs_sel !== 2'd1 || {bus.pc_sel, bus.flush_id, bus.stall_if} !== 3'b110) begin
            tests_failed++;
            $display("FAIL alu_resolve got fwd %0d sel/flush/stall %b want 1 110",
                     bus.fwd_rs_sel, {bus.pc_sel, bus.flush_id, bus.stall_if});
        end
        @(negedge clock);
        idle_all();
        #2;
        tests_run++;
        if (bus.stall_count !== 4'd1 || bus.branch_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL alu_counts got stall %0d branch %0d want 1 1", bus.stall_count, bus.branch_count);
        end
    endtask

    task automatic test_load_hazard();
        do_reset();
        set_id(V_BLTZ, 5'd3, 5'd0, 1'b0, 32'h0000_0200);
        set_ex(1'b1, 5'd3, 1'b1);
        #2;
        tests_run++;
        if ({bus.stall_if, bus.stall_id, bus.flush_ex} !== 3'b111) begin
            tests_failed++;
            $display("FAIL load_stall1 got %b want 111", {bus.stall_if, bus.stall_id, bus.flush_ex});
        end
        @(negedge clock);
        set_ex(1'b0, 5'd0, 1'b0);
        set_mem(1'b1, 5'd3, 1'b1);
        #2;
        tests_run++;
        if ({bus.stall_if, bus.stall_id, bus.flush_ex} !== 3'b111) begin
            tests_failed++;
            $display("FAIL load_stall2 got %b want 111", {bus.stall_if, bus.stall_id, bus.flush_ex});
        end
        @(negedge clock);
        set_mem(1'b0, 5'd0, 1'b0);
        set_wb(1'b1, 5'd3);
        #2;
        tests_run++;
        if (bus.fwd_rs_sel !== 2'd2 || {bus.pc_sel, bus.flush_id, bus.stall_if} !== 3'b000) begin
            tests_failed++;
            $display("FAIL load_resolve got fwd %0d sel/flush/stall %b want 2 000",
                     bus.fwd_rs_sel, {bus.pc_sel, bus.flush_id, bus.stall_if});
        end
        @(negedge clock);
        idle_all();
        #2;
        tests_run++;
        if (bus.stall_count !== 4'd2 || bus.branch_count !== 4'd1 || bus.taken_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL load_counts got %0d/%0d/%0d want 2/1/0",
                     bus.stall_count, bus.branch_count, bus.taken_count);
        end
    endtask

    task automatic test_jump_no_operand();
        do_reset();
        set_id(V_JR, 5'd0, 5'd0, 1'b1, 32'h0000_0300);
        set_ex(1'b1, 5'd0, 1'b1);
        #2;
        tests_run++;
        if ({bus.stall_if, bus.pc_sel, bus.flush_id} !== 3'b011 || bus.pc_target !== 32'h0000_0300) begin
            tests_failed++;
            $display("FAIL jr_r0 got stall/sel/flush %b target %h want 011 00000300",
                     {bus.stall_if, bus.pc_sel, bus.flush_id}, bus.pc_target);
        end
        @(negedge clock);
        set_id(V_J, 5'd5, 5'd5, 1'b1, 32'h0000_0400);
        set_ex(1'b1, 5'd5, 1'b1);
        #2;
        tests_run++;
        if ({bus.stall_if, bus.pc_sel, bus.flush_id} !== 3'b011 || bus.pc_target !== 32'h0000_0400) begin
            tests_failed++;
            $display("FAIL j_no_operand got stall/sel/flush %b target %h want 011 00000400",
                     {bus.stall_if, bus.pc_sel, bus.flush_id}, bus.pc_target);
        end
        @(negedge clock);
        idle_all();
        #2;
        tests_run++;
        if (bus.branch_count !== 4'd2 || bus.stall_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL jump_counts got branch %0d stall %0d want 2 0", bus.branch_count, bus.stall_count);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(V_BLTZ, 5'd3, 5'd0, 1'b1, 32'h0000_0500);
        set_ex(1'b1, 5'd3, 1'b1);
        @(negedge clock);
        set_ex(1'b0, 5'd0, 1'b0);
        set_mem(1'b1, 5'd3, 1'b1);
        #2;
        #1 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.stall_if, bus.stall_id, bus.flush_ex, bus.pc_sel} !== 4'b0000 || bus.stall_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL mid_stall_reset got ctrl %b stall_count %0d want 0000 0",
                     {bus.stall_if, bus.stall_id, bus.flush_ex, bus.pc_sel}, bus.stall_count);
        end
        @(negedge clock);
        reset_n = 1'b1;
        idle_all();
        set_id(V_BEQ, 5'd1, 5'd2, 1'b0, 32'h0000_0600);
        #2;
        tests_run++;
        if (bus.stall_if !== 1'b0 || {bus.branch_count, bus.taken_count, bus.stall_count} !== '0) begin
            tests_failed++;
            $display("FAIL after_reset got stall %b counters %h want 0 0",
                     bus.stall_if, {bus.branch_count, bus.taken_count, bus.stall_count});
        end
        @(negedge clock);
        idle_all();
        #2;
        tests_run++;
        if (bus.branch_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL after_reset_resolve got branch %0d want 1", bus.branch_count);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            set_id(V_JAL, 5'd0, 5'd0, 1'b1, 32'h0000_1000);
            @(negedge clock);
        end
        idle_all();
        #2;
        tests_run++;
        if (bus.branch_count !== 4'hF || bus.taken_count !== 4'hF) begin
            tests_failed++;
            $display("FAIL wrap_full got %0d/%0d want 15/15", bus.branch_count, bus.taken_count);
        end
        @(negedge clock);
        set_id(V_JAL, 5'd0, 5'd0, 1'b1, 32'h0000_1000);
        @(negedge clock);
        idle_all();
        #2;
        tests_run++;
        if (bus.branch_count !== 4'h0 || bus.taken_count !== 4'h0) begin
            tests_failed++;
            $display("FAIL wrap_zero got %0d/%0d want 0/0", bus.branch_count, bus.taken_count);
        end
    endtask

    // Reference: how many cycles a hazard must wait before the operand is forwardable.
    function automatic int ref_need(input logic [4:0] src);
        if (src == 5'd0) return 0;
        if (bus.ex_reg_write && bus.ex_write_reg == src) return bus.ex_mem_to_reg ? 2 : 1;
        if (bus.mem_reg_write && bus.mem_write_reg == src && bus.mem_mem_to_reg) return 1;
        return 0;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (src == 5'd0) return 2'd0;
        if (bus.mem_reg_write && bus.mem_write_reg == src && !bus.mem_mem_to_reg) return 2'd1;
        if (bus.wb_reg_write && bus.wb_write_reg == src) return 2'd2;
        return 2'd0;
    endfunction

    task automatic test_random();
        int pend, pend_n, n_rs, n_rt, n;
        int m_branch, m_taken, m_stall;
        bit act, e_stall, e_res, e_taken;
        logic [2:0] v;
        logic [52:0] got, want;
        do_reset();
        pend = 0; m_branch = 0; m_taken = 0; m_stall = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clock);
            v = 3'($urandom_range(0, 6));
            set_id(v, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $urandom);
            set_ex(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            set_mem(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
            #2;
            act   = (v != V_NONE);
            n_rs  = (v inside {V_BEQ, V_BNE, V_BLTZ, V_JR}) ? ref_need(bus.id_rs) : 0;
            n_rt  = (v inside {V_BEQ, V_BNE}) ? ref_need(bus.id_rt) : 0;
            n     = (n_rs > n_rt) ? n_rs : n_rt;
            e_stall = 1'b0; e_res = 1'b0; pend_n = pend;
            if (!act) pend_n = 0;
            else if (pend == 0) begin
                if (n == 0) e_res = 1'b1;
                else begin e_stall = 1'b1; pend_n = n; end
            end else if (pend >= 2) begin
                e_stall = 1'b1; pend_n = pend - 1;
            end else begin
                e_res = 1'b1; pend_n = 0;
            end
            e_taken = e_res && bus.id_pc_src;
            want = {e_stall, e_stall, e_stall, e_taken,
                    act ? ref_fwd(bus.id_rs) : 2'd0, act ? ref_fwd(bus.id_rt) : 2'd0,
                    e_taken, e_taken ? bus.id_jump_address : 32'h0,
                    CW'(m_branch), CW'(m_taken), CW'(m_stall)};
            got  = {bus.stall_if, bus.stall_id, bus.flush_ex, bus.flush_id,
                    bus.fwd_rs_sel, bus.fwd_rt_sel, bus.pc_sel, bus.pc_target,
                    bus.branch_count, bus.taken_count, bus.stall_count};
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL random_cycle%0d got %h want %h", cyc, got, want);
            end
            @(posedge clock);
            pend = pend_n;
            m_branch += int'(e_res);
            m_taken  += int'(e_taken);
            m_stall  += int'(e_stall);
        end
        @(negedge clock);
        idle_all();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_taken_beq();
        test_ex_alu_hazard();
        test_load_hazard();
        test_jump_no_operand();
        test_reset_mid_stall();
        test_counter_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
